reorder_buffer: RTL and testbench

- In-order retirement end of the rename/allocate protocol.
- Accepts renamed instructions, each with a ROB tag, pd_new and pd_old, from the rename stage into a circular buffer.
- Marks entries complete on functional-unit writeback and retires them strictly in order, one per cycle.
- On retire, returns pd_old to the free list. On a mispredicted branch writeback, squashes all younger entries and pulses mispredict back to rename.

---
 rtl/reorder_buffer.sv | 140 ++++++++++++++
 tb/tb_reorder_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement, writeback completion and branch-mispredict squash.
// Optional perf counters (perf_commits, perf_flushes) enabled by defining ROB_PERF_CNT_EN.
module reorder_buffer #(
   parameter int DEPTH  = 16,
   parameter int PREG_W = 7,
   localparam int TAG_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [PREG_W-1:0] alloc_pd_new,
   input  logic [PREG_W-1:0] alloc_pd_old,
   input  logic              alloc_is_branch,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   input  logic              wb_mispredict,
   output logic              free_valid,
   output logic [PREG_W-1:0] free_preg,
   output logic              commit_valid,
   output logic [TAG_W-1:0]  commit_tag,
   output logic              mispredict,
   output logic              full,
   output logic              empty
`ifdef ROB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_commits,
   output logic [31:0]       perf_flushes
`endif
);

   logic [DEPTH-1:0]  valid_q, valid_next;
   logic [DEPTH-1:0]  done_q, done_next;
   logic [DEPTH-1:0]  branch_q;
   logic [PREG_W-1:0] pd_new_q [DEPTH];
   logic [PREG_W-1:0] pd_old_q [DEPTH];

   logic [TAG_W-1:0]  head_q, tail_q;
   logic [TAG_W:0]    count_q, count_next;
   logic              flush_q;

   logic              alloc_fire, retire_fire, flush_event;
   logic [TAG_W-1:0]  wb_dist, rel;
   logic [TAG_W:0]    keep_count, retire_dec;

   assign full        = (count_q == (TAG_W+1)'(DEPTH));
   assign empty       = (count_q == '0);
   assign alloc_ready = !full && !flush_q;
   assign alloc_tag   = tail_q;
   assign mispredict  = flush_q;

   assign alloc_fire  = alloc_valid && alloc_ready;
   assign retire_fire = valid_q[head_q] && done_q[head_q];
   assign flush_event = wb_valid && wb_mispredict && valid_q[wb_tag] && branch_q[wb_tag];

   // Entries kept after a squash run from head up to and including the branch.
   assign wb_dist    = wb_tag - head_q;
   assign keep_count = {1'b0, wb_dist} + (TAG_W+1)'(1);
   assign retire_dec = {{TAG_W{1'b0}}, retire_fire};

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      valid_next = valid_q;
      done_next  = done_q;
      rel        = '0;
      count_next = count_q + {{TAG_W{1'b0}}, alloc_fire} - retire_dec;
      if (retire_fire)
         valid_next[head_q] = 1'b0;
      if (wb_valid && valid_q[wb_tag])
         done_next[wb_tag] = 1'b1;
      if (flush_event) begin
         // A same-cycle allocation is younger than the branch and is simply dropped.
         for (int i = 0; i < DEPTH; i++) begin
            rel = TAG_W'(i) - head_q;
            if (rel > wb_dist)
               valid_next[i] = 1'b0;
         end
         count_next = keep_count - retire_dec;
      end else if (alloc_fire) begin
         valid_next[tail_q] = 1'b1;
         done_next[tail_q]  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= '0;
         done_q       <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         flush_q      <= 1'b0;
         commit_valid <= 1'b0;
         commit_tag   <= '0;
         free_valid   <= 1'b0;
         free_preg    <= '0;
      end else begin
         valid_q      <= valid_next;
         done_q       <= done_next;
         count_q      <= count_next;
         flush_q      <= flush_event;
         commit_valid <= retire_fire;
         commit_tag   <= retire_fire ? head_q : '0;
         free_valid   <= retire_fire && (pd_new_q[head_q] != '0);
         free_preg    <= (retire_fire && (pd_new_q[head_q] != '0)) ? pd_old_q[head_q] : '0;
         if (retire_fire)
            head_q <= head_q + TAG_W'(1);
         if (flush_event)
            tail_q <= wb_tag + TAG_W'(1);
         else if (alloc_fire)
            tail_q <= tail_q + TAG_W'(1);
      end
   end

   // NOTE: payload storage has no reset; valid_q alone decides whether an entry means anything.
   always_ff @(posedge clk) begin
      if (alloc_fire && !flush_event) begin
         pd_new_q[tail_q] <= alloc_pd_new;
         pd_old_q[tail_q] <= alloc_pd_old;
         branch_q[tail_q] <= alloc_is_branch;
      end
   end

`ifdef ROB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_commits <= '0;
         perf_flushes <= '0;
      end else begin
         if (retire_fire)
            perf_commits <= perf_commits + 32'd1;
         if (flush_event)
            perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected commits in allocation
// order, a negedge monitor pops and compares every commit the DUT presents.
module tb_reorder_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [6:0] alloc_pd_new;
   logic [6:0] alloc_pd_old;
   logic       alloc_is_branch;
   logic [3:0] alloc_tag;
   logic       wb_valid;
   logic [3:0] wb_tag;
   logic       wb_mispredict;
   logic       free_valid;
   logic [6:0] free_preg;
   logic       commit_valid;
   logic [3:0] commit_tag;
   logic       mispredict;
   logic       full;
   logic       empty;
`ifdef ROB_PERF_CNT_EN
   logic [31:0] perf_commits;
   logic [31:0] perf_flushes;
`endif

   reorder_buffer #(.DEPTH(16), .PREG_W(7)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
      .alloc_is_branch(alloc_is_branch), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_mispredict(wb_mispredict),
      .free_valid(free_valid), .free_preg(free_preg),
      .commit_valid(commit_valid), .commit_tag(commit_tag),
      .mispredict(mispredict), .full(full), .empty(empty)
`ifdef ROB_PERF_CNT_EN
      , .perf_commits(perf_commits), .perf_flushes(perf_flushes)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] tag;
      logic       fv;
      logic [6:0] fp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_commits = 0;
   int   exp_tail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented commit must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (commit_valid) begin
            n_commits++;
            if (sb.size() == 0) begin
               check("unexpected_commit", {28'd0, commit_tag}, 32'hFFFF_FFFF);
            end else begin
               check("commit_tag", {28'd0, commit_tag}, {28'd0, sb[0].tag});
               check("free_valid", {31'd0, free_valid}, {31'd0, sb[0].fv});
               check("free_preg", {25'd0, free_preg}, {25'd0, sb[0].fp});
               void'(sb.pop_front());
            end
         end else if (free_valid) begin
            check("free_without_commit", {31'd0, free_valid}, 32'd0);
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      sb.delete();
      exp_tail = 0;
      tick();
   endtask

   task automatic alloc(input logic [6:0] pn, input logic [6:0] po, input logic br);
      exp_t e;
      alloc_valid = 1'b1; alloc_pd_new = pn; alloc_pd_old = po; alloc_is_branch = br;
      check("alloc_ready", {31'd0, alloc_ready}, 32'd1);
      check("alloc_tag", {28'd0, alloc_tag}, exp_tail);
      e.tag = 4'(exp_tail);
      e.fv  = (pn != 7'd0);
      e.fp  = (pn != 7'd0) ? po : 7'd0;
      sb.push_back(e);
      exp_tail = (exp_tail + 1) % 16;
      tick();
      alloc_valid = 1'b0; alloc_is_branch = 1'b0;
   endtask

   task automatic wb(input logic [3:0] tag, input logic mp);
      wb_valid = 1'b1; wb_tag = tag; wb_mispredict = mp;
      tick();
      wb_valid = 1'b0; wb_mispredict = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      check(name, sb.size(), 32'd0);
   endtask

   initial begin
      int base;
      reset = 1'b1; alloc_valid = 1'b0; alloc_pd_new = '0; alloc_pd_old = '0;
      alloc_is_branch = 1'b0; wb_valid = 1'b0; wb_tag = '0; wb_mispredict = 1'b0;

      // Reset state
      do_reset();
      check("rst_alloc_ready", {31'd0, alloc_ready}, 32'd1);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
      check("rst_free_valid", {31'd0, free_valid}, 32'd0);
      check("rst_mispredict", {31'd0, mispredict}, 32'd0);
      check("rst_free_preg", {25'd0, free_preg}, 32'd0);
      check("rst_commit_tag", {28'd0, commit_tag}, 32'd0);

      // Out-of-order completion, in-order commit
      alloc(7'd33, 7'd1, 1'b0);
      alloc(7'd34, 7'd2, 1'b0);
      alloc(7'd35, 7'd3, 1'b0);
      check("empty_after_alloc", {31'd0, empty}, 32'd0);
      base = n_commits;
      wb(4'd2, 1'b0);
      repeat (3) tick();
      check("no_commit_before_head", n_commits - base, 32'd0);
      wb(4'd0, 1'b0);
      wb(4'd1, 1'b0);
      drain("drain_inorder");
      check("empty_after_drain", {31'd0, empty}, 32'd1);

      // Fill, full, wrap, allocate alongside retire
      do_reset();
      for (int i = 0; i < 16; i++) alloc(7'(i + 1), 7'(i + 20), 1'b0);
      check("full_at_16", {31'd0, full}, 32'd1);
      check("ready_low_full", {31'd0, alloc_ready}, 32'd0);
      wb(4'd0, 1'b0);
      tick();
      check("full_after_retire", {31'd0, full}, 32'd0);
      alloc(7'd60, 7'd61, 1'b0);          // wraps to tag 0
      check("full_again", {31'd0, full}, 32'd1);
      wb(4'd1, 1'b0);
      wb(4'd2, 1'b0);                     // retires tag 1 on this edge
      alloc(7'd62, 7'd63, 1'b0);          // same edge as tag 2 retire
      check("count_held_not_full", {31'd0, full}, 32'd0);
      alloc(7'd64, 7'd65, 1'b0);
      check("full_after_one_more", {31'd0, full}, 32'd1);
      for (int i = 3; i < 19; i++) wb(4'(i % 16), 1'b0);
      drain("drain_full");

      // Store with no destination frees nothing
      do_reset();
      alloc(7'd0, 7'd9, 1'b0);
      wb(4'd0, 1'b0);
      drain("drain_store");

      // Mispredict squash, with a same-cycle allocation that must be discarded
      do_reset();
      for (int i = 0; i < 6; i++) alloc(7'(50 + i), 7'(10 + i), (i == 2));
      wb_valid = 1'b1; wb_tag = 4'd2; wb_mispredict = 1'b1;
      alloc_valid = 1'b1; alloc_pd_new = 7'd99; alloc_pd_old = 7'd98;
      tick();
      wb_valid = 1'b0; wb_mispredict = 1'b0; alloc_valid = 1'b0;
      repeat (3) void'(sb.pop_back());
      exp_tail = 3;
      check("mispredict_pulse", {31'd0, mispredict}, 32'd1);
      check("ready_low_flush", {31'd0, alloc_ready}, 32'd0);
      tick();
      check("mispredict_one_cycle", {31'd0, mispredict}, 32'd0);
      check("tag_after_squash", {28'd0, alloc_tag}, 32'd3);
      wb(4'd4, 1'b0);                     // squashed entries ignore writeback
      wb(4'd5, 1'b0);
      wb(4'd0, 1'b1);                     // mispredict flag on a non-branch
      tick();
      check("nonbranch_no_pulse", {31'd0, mispredict}, 32'd0);
      wb(4'd1, 1'b0);
      alloc(7'd70, 7'd71, 1'b0);
      wb(4'd3, 1'b0);
      drain("drain_squash");
`ifdef ROB_PERF_CNT_EN
      check("perf_commits", perf_commits, 32'd4);
      check("perf_flushes", perf_flushes, 32'd1);
`endif

      // Reset mid-operation drops everything
      do_reset();
      for (int i = 0; i < 5; i++) alloc(7'(80 + i), 7'(90 + i), 1'b0);
      wb(4'd0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      exp_tail = 0;
      check("empty_after_reset", {31'd0, empty}, 32'd1);
      check("free_after_reset", {31'd0, free_valid}, 32'd0);
      base = n_commits;
      for (int i = 0; i < 5; i++) wb(4'(i), 1'b0);
      repeat (4) tick();
      check("no_commit_after_reset", n_commits - base, 32'd0);
      check("tag_after_reset", {28'd0, alloc_tag}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
